// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite SRAM slave.
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   sram_r_state_t          : read channel state machine states
//   sram_w_state_t          : write channel state machine states
package axi4_lite_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      R_IDLE,
      R_DELAY,
      R_VALID
   } sram_r_state_t;

   typedef enum logic [2:0] {
      W_IDLE,
      W_HAVE_AW,
      W_HAVE_W,
      W_DELAY,
      W_RESP
   } sram_w_state_t;

endpackage

// File: rtl/axi4_lite_sram_if.sv
// AXI4-Lite bus bundle between the core master and the SRAM slave.
//   AR/R : read address and read data channels
//   AW/W : write address and write data channels
//   B    : write response channel
// Modports: master (drives address/data/ready-for-response), slave (the SRAM).
interface axi4_lite_sram_if;

   logic [31:0] ARADDR;
   logic        ARVALID;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY;
   logic [31:0] AWADDR;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;

   modport master (
      output ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
      input  ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID
   );

   modport slave (
      input  ARADDR, ARVALID, RREADY, AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
      output ARREADY, RDATA, RRESP, RVALID, AWREADY, WREADY, BRESP, BVALID
   );

endinterface

// File: rtl/axi4_lite_sram_lfsr8.sv
// 8-bit maximal-length Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1.
// Advances once per clock; loads SEED on synchronous reset.
//   clk    : clock
//   rst    : synchronous active-high reset
//   lfsr_o : current LFSR state
module lfsr8 #(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] lfsr_o
);

   logic [7:0] lfsr_q;
   logic [7:0] lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   end

   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= SEED;
      else     lfsr_q <= lfsr_d;
   end

   assign lfsr_o = lfsr_q;

endmodule

// File: rtl/axi4_lite_sram.sv
// AXI4-Lite slave backed by word-addressed on-chip SRAM with a per-channel
// response delay. Read and write channels are independent state machines
// sharing one memory array.
//   clk : clock, all logic on posedge
//   rst : synchronous active-high reset (ready outputs forced low while high)
//   bus : AXI4-Lite slave modport (AR, R, AW, W, B channels)
// Build option AXI4_LITE_SRAM_RAND_DELAY_EN: delay taken from lfsr[2:0] of an
// lfsr8 instance; otherwise the delay is FIXED_DELAY.
module axi4_lite_sram
   import axi4_lite_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned FIXED_DELAY = 1,
   parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
   input logic              clk,
   input logic              rst,
   axi4_lite_sram_if.slave  bus
);

   localparam int unsigned IDXW = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [2:0]  delay;

`ifdef AXI4_LITE_SRAM_RAND_DELAY_EN
   logic [7:0] lfsr;
   lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .lfsr_o (lfsr)
   );
   assign delay = lfsr[2:0];
`else
   assign delay = 3'(FIXED_DELAY);
`endif

   function automatic logic addr_hit(input logic [31:0] a);
      return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
   endfunction

   function automatic logic [IDXW-1:0] word_idx(input logic [31:0] a);
      return IDXW'((a - BASE_ADDR) >> 2);
   endfunction

   // ---------------- read channel ----------------
   sram_r_state_t   r_state_q, r_state_d;
   logic [2:0]      r_cnt_q, r_cnt_d;
   logic            r_hit_q;
   logic [IDXW-1:0] r_idx_q;
   logic [31:0]     rdata_q;
   logic [1:0]      rresp_q;
   logic            ar_fire;
   logic            r_load;

   always_comb begin
      r_state_d   = r_state_q;
      r_cnt_d     = r_cnt_q;
      r_load      = 1'b0;
      bus.ARREADY = !rst && (r_state_q == R_IDLE);
      ar_fire     = bus.ARVALID && bus.ARREADY;
      unique case (r_state_q)
         R_IDLE: if (ar_fire) begin
            r_state_d = R_DELAY;
            r_cnt_d   = delay;
         end
         // One cycle spent here even for a zero delay, so RVALID appears
         // 1+d cycles after the address handshake.
         R_DELAY: if (r_cnt_q == 3'd0) begin
            r_state_d = R_VALID;
            r_load    = 1'b1;
         end else begin
            r_cnt_d = r_cnt_q - 3'd1;
         end
         R_VALID: if (bus.RREADY) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q <= R_IDLE;
         r_cnt_q   <= '0;
         r_hit_q   <= 1'b0;
         r_idx_q   <= '0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
      end else begin
         r_state_q <= r_state_d;
         r_cnt_q   <= r_cnt_d;
         if (ar_fire) begin
            r_hit_q <= addr_hit(bus.ARADDR);
            r_idx_q <= word_idx(bus.ARADDR);
         end
         // Sampled on the same edge as any write commit, so it sees old data.
         if (r_load) begin
            rdata_q <= r_hit_q ? mem_q[r_idx_q] : '0;
            rresp_q <= r_hit_q ? RESP_OKAY : RESP_SLVERR;
         end
      end
   end

   assign bus.RVALID = (r_state_q == R_VALID);
   assign bus.RDATA  = rdata_q;
   assign bus.RRESP  = rresp_q;

   // ---------------- write channel ----------------
   sram_w_state_t   w_state_q, w_state_d;
   logic [2:0]      w_cnt_q, w_cnt_d;
   logic            w_hit_q;
   logic [IDXW-1:0] w_idx_q;
   logic [31:0]     wdata_q;
   logic [3:0]      wstrb_q;
   logic [1:0]      bresp_q;
   logic            aw_fire;
   logic            w_fire;
   logic            w_commit;

   always_comb begin
      w_state_d   = w_state_q;
      w_cnt_d     = w_cnt_q;
      w_commit    = 1'b0;
      bus.AWREADY = !rst && ((w_state_q == W_IDLE) || (w_state_q == W_HAVE_W));
      bus.WREADY  = !rst && ((w_state_q == W_IDLE) || (w_state_q == W_HAVE_AW));
      aw_fire     = bus.AWVALID && bus.AWREADY;
      w_fire      = bus.WVALID && bus.WREADY;
      unique case (w_state_q)
         W_IDLE: begin
            if (aw_fire && w_fire) begin
               w_state_d = W_DELAY;
               w_cnt_d   = delay;
            end else if (aw_fire) begin
               w_state_d = W_HAVE_AW;
            end else if (w_fire) begin
               w_state_d = W_HAVE_W;
            end
         end
         W_HAVE_AW: if (w_fire) begin
            w_state_d = W_DELAY;
            w_cnt_d   = delay;
         end
         W_HAVE_W: if (aw_fire) begin
            w_state_d = W_DELAY;
            w_cnt_d   = delay;
         end
         W_DELAY: if (w_cnt_q == 3'd0) begin
            w_state_d = W_RESP;
            w_commit  = 1'b1;
         end else begin
            w_cnt_d = w_cnt_q - 3'd1;
         end
         W_RESP: if (bus.BREADY) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state_q <= W_IDLE;
         w_cnt_q   <= '0;
         w_hit_q   <= 1'b0;
         w_idx_q   <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bresp_q   <= RESP_OKAY;
      end else begin
         w_state_q <= w_state_d;
         w_cnt_q   <= w_cnt_d;
         if (aw_fire) begin
            w_hit_q <= addr_hit(bus.AWADDR);
            w_idx_q <= word_idx(bus.AWADDR);
         end
         if (w_fire) begin
            wdata_q <= bus.WDATA;
            wstrb_q <= bus.WSTRB;
         end
         if (w_commit) bresp_q <= w_hit_q ? RESP_OKAY : RESP_SLVERR;
      end
   end

   // Memory has no reset; rst only blocks a commit that lands on a reset edge.
   always_ff @(posedge clk) begin
      if (!rst && w_commit && w_hit_q) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (wstrb_q[b]) mem_q[w_idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

   assign bus.BVALID = (w_state_q == W_RESP);
   assign bus.BRESP  = bresp_q;

endmodule

// File: tb/tb_axi4_lite_sram.sv
module tb_axi4_lite_sram;

   localparam logic [31:0] BASE = 32'h8000_0000;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   n_vec = 0;
   int   n_err = 0;

   axi4_lite_sram_if bus ();

   axi4_lite_sram #(.FIXED_DELAY(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not end, got running want finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   logic [31:0] mm [1024];
   bit          m_rbusy = 0;
   int          m_rdue  = 0;
   logic [31:0] m_raddr = '0;
   logic [31:0] m_rdata = '0;
   logic [1:0]  m_rresp = '0;
   bit          m_aw = 0;
   bit          m_w  = 0;
   int          m_wdue = 0;
   logic [31:0] m_awaddr = '0;
   logic [31:0] m_wdata = '0;
   logic [3:0]  m_wstrb = '0;
   logic [1:0]  m_bresp = '0;

`ifdef AXI4_LITE_SRAM_RAND_DELAY_EN
   logic [7:0] m_lfsr = 8'hA5;
   always @(posedge clk) begin
      if (rst) m_lfsr = 8'hA5;
      else     m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end
`endif

   function automatic bit in_range(input logic [31:0] a);
      return (a >= 32'h8000_0000) && (a < 32'h8000_1000);
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a - 32'h8000_0000) >> 2);
   endfunction

   // Compare process: every negedge, all slave outputs against the model.
   always @(negedge clk) begin : compare
      int  d;
      bit  e_arr, e_awr, e_wr, e_rv, e_bv;
      bit  ar_hs, r_hs, aw_hs, w_hs, b_hs;
`ifdef AXI4_LITE_SRAM_RAND_DELAY_EN
      d = int'(m_lfsr[2:0]);
`else
      d = 2;
`endif
      // read sample precedes any write commit landing on the same edge
      if (m_rbusy && cyc == m_rdue) begin
         if (in_range(m_raddr)) begin
            m_rdata = mm[widx(m_raddr)];
            m_rresp = 2'b00;
         end else begin
            m_rdata = '0;
            m_rresp = 2'b10;
         end
      end
      if (m_aw && m_w && cyc == m_wdue) begin
         if (in_range(m_awaddr)) begin
            for (int b = 0; b < 4; b++)
               if (m_wstrb[b]) mm[widx(m_awaddr)][8*b +: 8] = m_wdata[8*b +: 8];
            m_bresp = 2'b00;
         end else begin
            m_bresp = 2'b10;
         end
      end
      e_arr = !rst && !m_rbusy;
      e_awr = !rst && !m_aw;
      e_wr  = !rst && !m_w;
      e_rv  = m_rbusy && (cyc >= m_rdue);
      e_bv  = m_aw && m_w && (cyc >= m_wdue);
      chk("ARREADY", 32'(bus.ARREADY), 32'(e_arr));
      chk("AWREADY", 32'(bus.AWREADY), 32'(e_awr));
      chk("WREADY",  32'(bus.WREADY),  32'(e_wr));
      chk("RVALID",  32'(bus.RVALID),  32'(e_rv));
      chk("BVALID",  32'(bus.BVALID),  32'(e_bv));
      chk("RDATA",   bus.RDATA,        m_rdata);
      chk("RRESP",   32'(bus.RRESP),   32'(m_rresp));
      chk("BRESP",   32'(bus.BRESP),   32'(m_bresp));
      ar_hs = bus.ARVALID && e_arr;
      r_hs  = e_rv && bus.RREADY;
      aw_hs = bus.AWVALID && e_awr;
      w_hs  = bus.WVALID && e_wr;
      b_hs  = e_bv && bus.BREADY;
      if (r_hs) m_rbusy = 0;
      if (ar_hs) begin
         m_rbusy = 1;
         m_raddr = bus.ARADDR;
         m_rdue  = cyc + 2 + d;
      end
      if (b_hs) begin
         m_aw = 0;
         m_w  = 0;
      end
      if (aw_hs) begin
         m_aw     = 1;
         m_awaddr = bus.AWADDR;
      end
      if (w_hs) begin
         m_w       = 1;
         m_wdata   = bus.WDATA;
         m_wstrb   = bus.WSTRB;
      end
      if ((aw_hs || w_hs) && m_aw && m_w) m_wdue = cyc + 2 + d;
      if (rst) begin
         m_rbusy = 0;
         m_aw    = 0;
         m_w     = 0;
         m_rdata = '0;
         m_rresp = '0;
         m_bresp = '0;
      end
   end

   // ---------------- drivers ----------------
   task automatic axi_read(input logic [31:0] addr, input int hold,
                           output logic [31:0] data, output logic [1:0] resp, output int lat);
      bit hs, seen;
      int t;
      data = '0;
      resp = '0;
      lat  = -1;
      bus.ARADDR  = addr;
      bus.ARVALID = 1'b1;
      hs = 0;
      t  = 0;
      while (!hs && t < 60) begin
         @(negedge clk);
         hs = bus.ARREADY;
         @(posedge clk);
         #1;
         t++;
      end
      bus.ARVALID = 1'b0;
      chk("ar_handshake", 32'(hs), 32'd1);
      if (!hs) return;
      seen = 0;
      t    = 0;
      while (!seen && t < 40) begin
         @(negedge clk);
         if (bus.RVALID) seen = 1;
         else t++;
      end
      chk("rvalid_seen", 32'(seen), 32'd1);
      if (!seen) return;
      lat  = t;
      data = bus.RDATA;
      resp = bus.RRESP;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("bp_rvalid_held", 32'(bus.RVALID), 32'd1);
         chk("bp_arready_low", 32'(bus.ARREADY), 32'd0);
      end
      @(posedge clk);
      #1;
      bus.RREADY = 1'b1;
      @(posedge clk);
      #1;
      bus.RREADY = 1'b0;
   endtask

   // gap > 0: W leads AW by gap cycles; gap < 0: AW leads W by -gap cycles.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int gap, input int hold, output logic [1:0] resp);
      bit awd, wd, a_hs, w_hs, seen;
      int t, aw_t, w_t;
      resp = '0;
      aw_t = (gap >= 0) ? gap : 0;
      w_t  = (gap >= 0) ? 0 : -gap;
      bus.AWADDR = addr;
      bus.WDATA  = data;
      bus.WSTRB  = strb;
      awd = 0;
      wd  = 0;
      t   = 0;
      while (!(awd && wd) && t < 60) begin
         bus.AWVALID = !awd && (t >= aw_t);
         bus.WVALID  = !wd && (t >= w_t);
         @(negedge clk);
         a_hs = bus.AWVALID && bus.AWREADY;
         w_hs = bus.WVALID && bus.WREADY;
         @(posedge clk);
         #1;
         awd = awd | a_hs;
         wd  = wd | w_hs;
         t++;
      end
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
      chk("aw_w_handshake", 32'(awd && wd), 32'd1);
      if (!(awd && wd)) return;
      seen = 0;
      t    = 0;
      while (!seen && t < 40) begin
         @(negedge clk);
         if (bus.BVALID) seen = 1;
         else t++;
      end
      chk("bvalid_seen", 32'(seen), 32'd1);
      if (!seen) return;
      resp = bus.BRESP;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("bp_bvalid_held", 32'(bus.BVALID), 32'd1);
         chk("bp_awready_low", 32'(bus.AWREADY), 32'd0);
      end
      @(posedge clk);
      #1;
      bus.BREADY = 1'b1;
      @(posedge clk);
      #1;
      bus.BREADY = 1'b0;
   endtask

   // Accept a write, then reset before its commit edge.
   task automatic axi_write_abort(input logic [31:0] addr, input logic [31:0] data);
      bit hs;
      int t;
      bus.AWADDR  = addr;
      bus.WDATA   = data;
      bus.WSTRB   = 4'hF;
      bus.AWVALID = 1'b1;
      bus.WVALID  = 1'b1;
      hs = 0;
      t  = 0;
      while (!hs && t < 60) begin
         @(negedge clk);
         hs = bus.AWREADY && bus.WREADY;
         @(posedge clk);
         #1;
         t++;
      end
      bus.AWVALID = 1'b0;
      bus.WVALID  = 1'b0;
      chk("abort_handshake", 32'(hs), 32'd1);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   function automatic logic [31:0] pick_addr();
      logic [31:0] miss [4];
      miss[0] = 32'h7FFF_FFFC;
      miss[1] = 32'h8000_1000;
      miss[2] = 32'h0000_0000;
      miss[3] = 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) == 0) return miss[$urandom_range(0, 3)];
      return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
   endfunction

   task automatic chk_lat(input string nm, input int lat);
`ifdef AXI4_LITE_SRAM_RAND_DELAY_EN
      chk(nm, 32'(lat >= 1 && lat <= 8), 32'd1);
`else
      chk(nm, 32'(lat), 32'd3);
`endif
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      logic [31:0] rd;
      logic [1:0]  rr, br;
      int          lat;
      bus.ARADDR  = '0;
      bus.ARVALID = 1'b0;
      bus.RREADY  = 1'b0;
      bus.AWADDR  = '0;
      bus.AWVALID = 1'b0;
      bus.WDATA   = '0;
      bus.WSTRB   = '0;
      bus.WVALID  = 1'b0;
      bus.BREADY  = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_readies_low", {29'd0, bus.ARREADY, bus.AWREADY, bus.WREADY}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_readies_high", {29'd0, bus.ARREADY, bus.AWREADY, bus.WREADY}, 32'd7);
      @(posedge clk);
      #1;

      for (int i = 0; i < 16; i++)
         axi_write(BASE + 32'(4 * i), 32'h1000_0000 + 32'(i * 32'h0101), 4'hF, 0, 0, br);

      axi_write(32'h8000_0010, 32'hDEADBEEF, 4'hF, 0, 0, br);
      chk("full_wr_bresp", 32'(br), 32'd0);
      axi_read(32'h8000_0010, 0, rd, rr, lat);
      chk("full_rd_data", rd, 32'hDEADBEEF);
      chk("full_rd_resp", 32'(rr), 32'd0);
      chk_lat("full_rd_latency", lat);

      axi_write(32'h8000_0010, 32'h0000_1200, 4'b0010, 0, 0, br);
      axi_read(32'h8000_0010, 0, rd, rr, lat);
      chk("partial_strobe", rd, 32'hDEAD12EF);

      axi_write(BASE + 32'h20, 32'hA5A5_0001, 4'hF, 4, 0, br);
      axi_read(BASE + 32'h20, 0, rd, rr, lat);
      chk("w_before_aw", rd, 32'hA5A5_0001);
      axi_write(BASE + 32'h24, 32'h5A5A_0002, 4'hF, -4, 0, br);
      axi_read(BASE + 32'h24, 0, rd, rr, lat);
      chk("aw_before_w", rd, 32'h5A5A_0002);

      axi_read(32'h7FFF_FFFC, 0, rd, rr, lat);
      chk("oor_rd_resp", 32'(rr), 32'd2);
      chk("oor_rd_data", rd, 32'd0);
      axi_write(32'h8000_1000, 32'h1234_5678, 4'hF, 0, 0, br);
      chk("oor_wr_bresp", 32'(br), 32'd2);
      axi_read(BASE, 0, rd, rr, lat);
      chk("word0_unchanged", rd, 32'h1000_0000);

      axi_write(BASE + 32'h28, 32'h0BAD_F00D, 4'hF, 0, 5, br);
      chk("bp_bresp", 32'(br), 32'd0);
      axi_read(BASE + 32'h28, 5, rd, rr, lat);
      chk("bp_rdata", rd, 32'h0BAD_F00D);

      fork
         axi_write(BASE + 32'h30, 32'hCAFE_F00D, 4'hF, 0, 0, br);
         axi_read(BASE + 32'h30, 0, rd, rr, lat);
      join
`ifndef AXI4_LITE_SRAM_RAND_DELAY_EN
      chk("same_edge_old_data", rd, 32'h1000_0C0C);
`endif
      axi_read(BASE + 32'h30, 0, rd, rr, lat);
      chk("same_edge_new_data", rd, 32'hCAFE_F00D);

      axi_write_abort(BASE + 32'h14, 32'hBAD0_BAD0);
      axi_read(BASE + 32'h14, 0, rd, rr, lat);
      chk("reset_drops_write", rd, 32'h1000_0505);

      for (int it = 0; it < 100; it++) begin
         logic [31:0] ra, wa, wd;
         logic [3:0]  ws;
         int          op;
         op = int'($urandom_range(0, 2));
         ra = pick_addr();
         wa = pick_addr();
         wd = $urandom;
         ws = 4'($urandom_range(0, 15));
         if (op == 1)
            axi_write(wa, wd, ws, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)), br);
         if (op == 2) begin
            fork
               axi_write(wa, wd, ws, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)), br);
               axi_read(ra, int'($urandom_range(0, 3)), rd, rr, lat);
            join
         end else begin
            axi_read(ra, int'($urandom_range(0, 3)), rd, rr, lat);
         end
         chk_lat("rand_rd_latency", lat);
      end

      repeat (4) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
